// File: rtl/sup1_control_unit.sv
// SUP-1 microcoded control sequencer: walks fetch/execute T-states, emits the
// bus control word, and owns the carry/zero flags and halt latch.
module sup1_control_unit #(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic              hlt,
  output logic              mi,
  output logic              ri,
  output logic              ro,
  output logic              ii,
  output logic              io,
  output logic              ai,
  output logic              ao,
  output logic              so,
  output logic              sub,
  output logic              bi,
  output logic              oi,
  output logic              ce,
  output logic              co,
  output logic              j,
  output logic              fi,
  output logic              flag_c,
  output logic              flag_z,
  output logic [STEP_W-1:0] step
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic so;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
    logic last;
  } ctrl_t;

  logic [STEP_W-1:0] step_q, step_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;
  logic              halted_q, halted_d;
  ctrl_t             ctrl;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    step_d   = step_q + STEP_W'(1);
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    halted_d = halted_q | ctrl.hlt;
    if (halted_q || ctrl.last) begin
      step_d = '0;
    end
    if (ctrl.fi) begin
      flag_c_d = carry_in;
      flag_z_d = zero_in;
    end
  end

  // Microcode decode; unreachable step/opcode combinations fall back to 'last'
  always_comb begin
    ctrl = '0;
    if (halted_q) begin
      ctrl.hlt = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          ctrl.co = 1'b1;
          ctrl.mi = 1'b1;
        end
        T1: begin
          ctrl.ro   = 1'b1;
          ctrl.ii   = 1'b1;
          ctrl.ce   = 1'b1;
          ctrl.last = (opcode == OP_NOP) || (opcode inside {[4'b1001:4'b1101]});
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.io = 1'b1;
              ctrl.mi = 1'b1;
            end
            OP_LDI: begin
              ctrl.io   = 1'b1;
              ctrl.ai   = 1'b1;
              ctrl.last = 1'b1;
            end
            OP_JMP: begin
              ctrl.io   = 1'b1;
              ctrl.j    = 1'b1;
              ctrl.last = 1'b1;
            end
            // Conditional jumps look only at the registered flags
            OP_JC: begin
              ctrl.io   = 1'b1;
              ctrl.j    = flag_c_q;
              ctrl.last = 1'b1;
            end
            OP_JZ: begin
              ctrl.io   = 1'b1;
              ctrl.j    = flag_z_q;
              ctrl.last = 1'b1;
            end
            OP_OUT: begin
              ctrl.ao   = 1'b1;
              ctrl.oi   = 1'b1;
              ctrl.last = 1'b1;
            end
            OP_HLT: begin
              ctrl.hlt  = 1'b1;
              ctrl.last = 1'b1;
            end
            default: ctrl.last = 1'b1;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ctrl.ro   = 1'b1;
              ctrl.ai   = 1'b1;
              ctrl.last = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ro  = 1'b1;
              ctrl.bi  = 1'b1;
              ctrl.sub = (opcode == OP_SUB);
            end
            OP_STA: begin
              ctrl.ao   = 1'b1;
              ctrl.ri   = 1'b1;
              ctrl.last = 1'b1;
            end
            default: ctrl.last = 1'b1;
          endcase
        end
        T4: begin
          ctrl.last = 1'b1;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.so  = 1'b1;
            ctrl.ai  = 1'b1;
            ctrl.fi  = 1'b1;
            ctrl.sub = (opcode == OP_SUB);
          end
        end
        default: ctrl.last = 1'b1;
      endcase
    end
  end

  assign hlt    = ctrl.hlt;
  assign mi     = ctrl.mi;
  assign ri     = ctrl.ri;
  assign ro     = ctrl.ro;
  assign ii     = ctrl.ii;
  assign io     = ctrl.io;
  assign ai     = ctrl.ai;
  assign ao     = ctrl.ao;
  assign so     = ctrl.so;
  assign sub    = ctrl.sub;
  assign bi     = ctrl.bi;
  assign oi     = ctrl.oi;
  assign ce     = ctrl.ce;
  assign co     = ctrl.co;
  assign j      = ctrl.j;
  assign fi     = ctrl.fi;
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
  assign step   = step_q;

endmodule

// File: tb/tb_sup1_control_unit.sv
// Directed bench for sup1_control_unit: walks each opcode's T-states and
// compares the full control word, step and flags against hand-written values.
module tb_sup1_control_unit;

  localparam logic [15:0] H   = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RI  = 16'h2000;
  localparam logic [15:0] RO  = 16'h1000;
  localparam logic [15:0] II  = 16'h0800;
  localparam logic [15:0] IO  = 16'h0400;
  localparam logic [15:0] AI  = 16'h0200;
  localparam logic [15:0] AO  = 16'h0100;
  localparam logic [15:0] SO  = 16'h0080;
  localparam logic [15:0] SB  = 16'h0040;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] OI  = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] CO  = 16'h0004;
  localparam logic [15:0] J   = 16'h0002;
  localparam logic [15:0] FI  = 16'h0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       carry_in, zero_in;
  logic       hlt, mi, ri, ro, ii, io, ai, ao, so, sub, bi, oi, ce, co, j, fi;
  logic       flag_c, flag_z;
  logic [2:0] step;
  logic [15:0] cw;

  int checks = 0;
  int failures = 0;

  sup1_control_unit #(.STEP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry_in(carry_in), .zero_in(zero_in),
    .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .ii(ii), .io(io), .ai(ai), .ao(ao),
    .so(so), .sub(sub), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
    .flag_c(flag_c), .flag_z(flag_z), .step(step)
  );

  assign cw = {hlt, mi, ri, ro, ii, io, ai, ao, so, sub, bi, oi, ce, co, j, fi};

  always #5 clk = ~clk;

  // At most one bus driver in any cycle, reset and halt included
  always @(negedge clk) begin
    checks++;
    assert ($countones({ro, io, ao, so, co}) <= 1) else begin
      failures++;
      $display("FAIL bus_excl drivers=%b required at most one", {ro, io, ao, so, co});
      $error("bus_excl");
    end
  end

  task automatic chk_cw(input string tag, input logic [15:0] exp_cw, input logic [2:0] exp_step);
    checks++;
    assert (cw === exp_cw) else begin
      failures++;
      $display("FAIL %s cw got=%h expected=%h", tag, cw, exp_cw);
      $error("%s cw", tag);
    end
    checks++;
    assert (step === exp_step) else begin
      failures++;
      $display("FAIL %s step got=%0d expected=%0d", tag, step, exp_step);
      $error("%s step", tag);
    end
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic z);
    checks++;
    assert ({flag_c, flag_z} === {c, z}) else begin
      failures++;
      $display("FAIL %s flags got=%b%b expected=%b%b", tag, flag_c, flag_z, c, z);
      $error("%s flags", tag);
    end
  endtask

  task automatic nstep(input string tag, input logic [15:0] exp_cw, input logic [2:0] exp_step);
    @(negedge clk);
    chk_cw(tag, exp_cw, exp_step);
  endtask

  // Entered at the negedge where T0 is showing; leaves at the T1 negedge
  task automatic fetch(input string tag, input logic [3:0] op);
    opcode = op;
    #1;
    chk_cw({tag, "_t0"}, CO | MI, 3'd0);
    nstep({tag, "_t1"}, RO | II | CE, 3'd1);
  endtask

  task automatic alu(input string tag, input logic is_sub, input logic c, input logic z);
    logic [15:0] s;
    s = is_sub ? SB : 16'h0000;
    fetch(tag, is_sub ? 4'b0011 : 4'b0010);
    nstep({tag, "_t2"}, IO | MI, 3'd2);
    nstep({tag, "_t3"}, RO | BI | s, 3'd3);
    nstep({tag, "_t4"}, SO | AI | FI | s, 3'd4);
    carry_in = c;
    zero_in  = z;
    @(negedge clk);
    chk_flags({tag, "_flags"}, c, z);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sequence did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    opcode = 4'b0101;
    carry_in = 1'b0;
    zero_in = 1'b0;
    #3;
    chk_cw("reset", CO | MI, 3'd0);
    chk_flags("reset", 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_cw("reset_hold", CO | MI, 3'd0);
    rst_n = 1'b1;

    // LDI: three cycles per instruction
    fetch("ldi", 4'b0101);
    nstep("ldi_t2", IO | AI, 3'd2);
    @(negedge clk);

    alu("add11", 1'b0, 1'b1, 1'b1);
    alu("add00", 1'b0, 1'b0, 1'b0);

    // JC not taken; live carry_in ignored
    fetch("jc0", 4'b0111);
    nstep("jc0_t2", IO, 3'd2);
    carry_in = 1'b1;
    #1;
    chk_cw("jc0_live_c", IO, 3'd2);
    @(negedge clk);
    chk_flags("jc0_hold", 1'b0, 1'b0);

    alu("add10", 1'b0, 1'b1, 1'b0);
    fetch("jc1", 4'b0111);
    nstep("jc1_t2", IO | J, 3'd2);
    carry_in = 1'b0;
    #1;
    chk_cw("jc1_live_c", IO | J, 3'd2);
    @(negedge clk);

    fetch("jz0", 4'b1000);
    nstep("jz0_t2", IO, 3'd2);
    zero_in = 1'b1;
    #1;
    chk_cw("jz0_live_z", IO, 3'd2);
    @(negedge clk);

    alu("add01", 1'b0, 1'b0, 1'b1);
    fetch("jz1", 4'b1000);
    nstep("jz1_t2", IO | J, 3'd2);
    zero_in = 1'b0;
    #1;
    chk_cw("jz1_live_z", IO | J, 3'd2);
    @(negedge clk);

    alu("sub11", 1'b1, 1'b1, 1'b1);

    fetch("sta", 4'b0100);
    nstep("sta_t2", IO | MI, 3'd2);
    nstep("sta_t3", AO | RI, 3'd3);
    @(negedge clk);

    fetch("jmp", 4'b0110);
    nstep("jmp_t2", IO | J, 3'd2);
    @(negedge clk);

    fetch("out", 4'b1110);
    nstep("out_t2", AO | OI, 3'd2);
    @(negedge clk);

    fetch("nop", 4'b0000);
    @(negedge clk);

    fetch("lda", 4'b0001);
    nstep("lda_t2", IO | MI, 3'd2);
    nstep("lda_t3", RO | AI, 3'd3);
    @(negedge clk);

    fetch("undef", 4'b1010);
    @(negedge clk);
    chk_cw("undef_ret", CO | MI, 3'd0);
    chk_flags("pre_hlt", 1'b1, 1'b1);

    // HLT, then stay halted with flags frozen
    fetch("hlt", 4'b1111);
    nstep("hlt_t2", H, 3'd2);
    carry_in = 1'b0;
    zero_in = 1'b0;
    for (int k = 0; k < 12; k++) nstep("halted", H, 3'd0);
    chk_flags("halted", 1'b1, 1'b1);

    rst_n = 1'b0;
    #1;
    chk_cw("rst_in_halt", CO | MI, 3'd0);
    chk_flags("rst_in_halt", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch("post_hlt", 4'b0101);
    nstep("post_hlt_t2", IO | AI, 3'd2);
    @(negedge clk);

    // Reset asserted in the middle of an ADD
    alu("add_pre", 1'b0, 1'b1, 1'b1);
    fetch("add_rst", 4'b0010);
    nstep("add_rst_t2", IO | MI, 3'd2);
    nstep("add_rst_t3", RO | BI, 3'd3);
    rst_n = 1'b0;
    #1;
    chk_cw("rst_mid_add", CO | MI, 3'd0);
    chk_flags("rst_mid_add", 1'b0, 1'b0);
    @(negedge clk);
    chk_cw("rst_mid_add_hold", CO | MI, 3'd0);
    rst_n = 1'b1;
    fetch("after_rst", 4'b0101);
    nstep("after_rst_t2", IO | AI, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sup1_control_unit.md
Name: sup1_control_unit

Overview:
- Microcoded control sequencer for the SUP-1 8-bit single-bus computer.
- Steps through fetch and execute T-states for each instruction and drives the control word that gates the shared bus. This includes the ALU `sub`/`so` controls.
- Holds the carry/zero flags register, loaded from the ALU flag outputs, and resolves conditional jumps from it.
- Sits between the instruction register's opcode nibble and every register's enable and strobe lines.

Parameters:
- STEP_W, 3, width of the T-state counter (supports T0..T7; only T0..T4 are used).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- opcode  input  4  upper nibble of the instruction register.
- carry_in  input  1  ALU carry output.
- zero_in  input  1  ALU zero output.
- hlt  output  1  halt indicator / clock-gate request.
- mi  output  1  memory address register in.
- ri  output  1  RAM in (write).
- ro  output  1  RAM out to bus.
- ii  output  1  instruction register in.
- io  output  1  instruction register operand (low nibble) out to bus.
- ai  output  1  A register in.
- ao  output  1  A register out to bus.
- so  output  1  ALU result out to bus.
- sub  output  1  ALU subtract select.
- bi  output  1  B register in.
- oi  output  1  output register in.
- ce  output  1  program counter increment.
- co  output  1  program counter out to bus.
- j  output  1  program counter load (jump).
- fi  output  1  flags register load.
- flag_c  output  1  registered carry flag.
- flag_z  output  1  registered zero flag.
- step  output  STEP_W  current T-state, for debug and bench use.

Behaviour:
- State: step counter, flags register {flag_c, flag_z}, and halted bit.
- Reset (rst_n low, asynchronous) forces:
  - step=0, flag_c=0, flag_z=0, halted=0.
  - All control outputs are combinational from state, so they take their T0 values immediately: co=1, mi=1, all others 0.
  - Reset takes effect even in the middle of an instruction. The first rising edge after rst_n rises executes T0.
- Control word is purely combinational from (step, opcode, flags, halted). It is valid for the whole cycle, and the registers it enables capture on the next rising edge.
- Step advance on each rising edge:
  - If the current microstep is flagged `last`, step returns to 0.
  - Otherwise step increments by 1.
- Fetch, common to all opcodes:
  - T0: co, mi.
  - T1: ro, ii, ce.
- Execute, starting at T2. `*` marks the last step.
  - 0000 NOP: T1 is last.
  - 0001 LDA: T2 io, mi. T3* ro, ai.
  - 0010 ADD: T2 io, mi. T3 ro, bi. T4* so, ai, fi.
  - 0011 SUB: as ADD, with sub=1 at both T3 and T4. sub must be stable for the cycle that so is asserted.
  - 0100 STA: T2 io, mi. T3* ao, ri.
  - 0101 LDI: T2* io, ai.
  - 0110 JMP: T2* io, j.
  - 0111 JC: T2* io, with j = flag_c.
  - 1000 JZ: T2* io, with j = flag_z.
  - 1110 OUT: T2* ao, oi.
  - 1111 HLT: T2* hlt, and halted is set at the end of the cycle.
  - 1001..1101 (undefined): treated as NOP, so T1 is last.
- Jump decision uses the flags register value in T2, not the live carry_in/zero_in.
- Flags register loads {carry_in, zero_in} on the rising edge that ends a cycle with fi=1. It holds its value otherwise.
- Halted state:
  - hlt=1 and every other control output=0. step freezes at 0 and the flags hold.
  - The block exits halt only through rst_n.
- Bus exclusivity invariant: at most one of {ro, io, ao, so, co} is 1 in any cycle, including during reset and halt.
- The output set of each step is exhaustive. Any signal not listed for a step is 0.

Test Plan:
- Release reset with opcode=0101 (LDI) -> T0 {co,mi}, T1 {ro,ii,ce}, T2 {io,ai}; step returns to 0 on the next edge, so 3 cycles per instruction.
- ADD with carry_in=1, zero_in=1 presented at T4 -> fi=1, so=1, ai=1 at T4; flag_c=1 and flag_z=1 after the edge. Then an ADD with carry_in=0, zero_in=0 -> both flags clear.
- JC with flag_c=0 -> T2 io=1, j=0. JC with flag_c=1 -> j=1. JZ checked the same way against flag_z. Toggling live carry_in during T2 has no effect.
- SUB -> sub=1 at T3 and T4, so=1 only at T4. STA -> T3 ao=1, ri=1, with so=0 and sub=0.
- HLT -> hlt=1 from T2 onward and all other outputs 0 for 10+ cycles. Asserting rst_n low mid-halt -> immediate step=0 with co=1 and mi=1.
- Opcode 1010 (undefined) -> returns to T0 after T1. Assert rst_n low at T3 of ADD -> outputs return to T0 values asynchronously and flags=0. The bus-exclusivity assertion holds throughout every scenario.
